// File: rtl/sub_i8_share_ctrl.sv
// Round-robin front end that time-shares one subtract unit among N requesters.
// Tags ride a latency-matched pipe so each result returns with its requester index.
module sub_i8_share_ctrl #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 0,
  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic [W-1:0]     sub_a,
  output logic [W-1:0]     sub_b,
  input  logic [W-1:0]     sub_y,
  output logic             rsp_valid,
  output logic [IdW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic             busy
);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] grant_id, scan_id;
  logic           grant_vld;
  logic           hs;
  logic [W-1:0]   op_a, op_b;

  logic [LAT:0]   tag_vld_q;
  logic [IdW-1:0] tag_id_q [LAT+1];

  // First valid requester at or after the pointer, wrapping mod N.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_id = IdW'((32'(ptr_q) + k) % N);
      if (!grant_vld && req_valid[scan_id]) begin
        grant_vld = 1'b1;
        grant_id  = scan_id;
      end
    end
    hs        = en & ~reset & grant_vld;
    req_ready = '0;
    if (hs) begin
      req_ready[grant_id] = 1'b1;
    end
    ptr_d = (grant_id == IdW'(N - 1)) ? '0 : grant_id + IdW'(1);
    op_a  = req_a[32'(grant_id) * W +: W];
    op_b  = req_b[32'(grant_id) * W +: W];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q     <= '0;
      sub_a     <= '0;
      sub_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i <= int'(LAT); i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      if (hs) begin
        sub_a <= op_a;
        sub_b <= op_b;
        ptr_q <= ptr_d;
      end
      tag_vld_q[0] <= hs;
      tag_id_q[0]  <= grant_id;
      for (int i = 1; i <= int'(LAT); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      // Last tag stage lines up with sub_y being valid for that op.
      rsp_valid <= tag_vld_q[LAT];
      if (tag_vld_q[LAT]) begin
        rsp_id <= tag_id_q[LAT];
        rsp_y  <= sub_y;
      end
    end
  end

  assign busy = |tag_vld_q;

endmodule

// File: tb/tb_sub_i8_share_ctrl.sv
// Scoreboard bench: two instances (LAT=0 and LAT=3) share directed stimulus;
// a negedge monitor checks every response, its cycle, busy and held outputs.
module tb_sub_i8_share_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;

  logic [3:0]  req_ready [2];
  logic [7:0]  sub_a [2];
  logic [7:0]  sub_b [2];
  logic [7:0]  sub_y [2];
  logic        rsp_valid [2];
  logic [1:0]  rsp_id [2];
  logic [7:0]  rsp_y [2];
  logic        busy [2];
  logic [7:0]  pipe [3];

  typedef struct {
    int         id;
    logic [7:0] y;
    int         due;
  } exp_t;

  exp_t       q [2][$];
  int         lat [2] = '{0, 3};
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       rst_seen = 1'b1;
  int         last_id [2] = '{0, 0};
  logic [7:0] last_y [2] = '{8'h00, 8'h00};

  sub_i8_share_ctrl #(.N(4), .W(8), .LAT(0)) dut0 (
    .clock(clock), .reset(reset), .en(en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready[0]),
    .sub_a(sub_a[0]), .sub_b(sub_b[0]), .sub_y(sub_y[0]),
    .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_y(rsp_y[0]), .busy(busy[0])
  );

  sub_i8_share_ctrl #(.N(4), .W(8), .LAT(3)) dut3 (
    .clock(clock), .reset(reset), .en(en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready[1]),
    .sub_a(sub_a[1]), .sub_b(sub_b[1]), .sub_y(sub_y[1]),
    .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_y(rsp_y[1]), .busy(busy[1])
  );

  // Shared subtract units: combinational for dut0, three register stages for dut3.
  assign sub_y[0] = sub_a[0] - sub_b[0];
  assign sub_y[1] = pipe[2];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
    pipe[0]  <= sub_a[1] - sub_b[1];
    pipe[1]  <= pipe[0];
    pipe[2]  <= pipe[1];
  end

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (LAT=%0d) cycle %0d: got %0h, expected %0h", name, lat[d], cyc, act, exp);
    end
  endtask

  task automatic mon(input int d);
    logic exp_v;
    logic exp_busy;
    exp_t e;
    if (rst_seen) begin
      last_id[d] = 0;
      last_y[d]  = 8'h00;
    end
    exp_v    = (q[d].size() > 0) && (q[d][0].due == cyc);
    exp_busy = 1'b0;
    for (int i = 0; i < q[d].size(); i++) begin
      if (q[d][i].due > cyc) exp_busy = 1'b1;
    end
    chk("busy", d, 32'(busy[d]), 32'(exp_busy));
    chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(exp_v));
    if (exp_v) begin
      e = q[d].pop_front();
      if (rsp_valid[d]) begin
        chk("rsp_id", d, 32'(rsp_id[d]), 32'(e.id));
        chk("rsp_y", d, 32'(rsp_y[d]), 32'(e.y));
      end
      last_id[d] = e.id;
      last_y[d]  = e.y;
    end else if (!rsp_valid[d]) begin
      chk("rsp_id_hold", d, 32'(rsp_id[d]), 32'(last_id[d]));
      chk("rsp_y_hold", d, 32'(rsp_y[d]), 32'(last_y[d]));
    end
  endtask

  always @(negedge clock) begin
    mon(0);
    mon(1);
  end

  function automatic logic [31:0] pk(input logic [7:0] x0, input logic [7:0] x1,
                                     input logic [7:0] x2, input logic [7:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  // One cycle of stimulus; queue updates happen after the monitor has sampled.
  task automatic step(input logic rst, input logic e, input logic [3:0] v,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] exp_rdy, input logic [7:0] exp_y);
    int id;
    @(negedge clock);
    reset     = rst;
    en        = e;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("req_ready", d, 32'(req_ready[d]), 32'(exp_rdy));
      if (rst) begin
        for (int i = q[d].size() - 1; i >= 0; i--) begin
          if (q[d][i].due > cyc) q[d].delete(i);
        end
      end
    end
    if (exp_rdy != 4'b0000) begin
      id = 0;
      for (int i = 0; i < 4; i++) begin
        if (exp_rdy[i]) id = i;
      end
      for (int d = 0; d < 2; d++) begin
        q[d].push_back('{id: id, y: exp_y, due: cyc + lat[d] + 2});
      end
    end
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, e, 4'b0000, '0, '0, 4'b0000, 8'h00);
  endtask

  logic [31:0] all_a;
  logic [31:0] all_b;
  logic [3:0]  seq_all [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    all_a = pk(8'd10, 8'd11, 8'd12, 8'd13);
    all_b = pk(8'd0, 8'd1, 8'd2, 8'd3);

    // Reset: no grants while reset is high, operand registers cleared.
    step(1'b1, 1'b1, 4'b1111, all_a, all_b, 4'b0000, 8'h00);
    for (int d = 0; d < 2; d++) begin
      chk("sub_a_reset", d, 32'(sub_a[d]), 32'h0);
      chk("sub_b_reset", d, 32'(sub_b[d]), 32'h0);
    end
    step(1'b1, 1'b1, 4'b1111, all_a, all_b, 4'b0000, 8'h00);

    // Single op from requester 0: 9 - 3 = 6.
    step(1'b0, 1'b1, 4'b0001, pk(8'd9, 8'd0, 8'd0, 8'd0), pk(8'd3, 8'd0, 8'd0, 8'd0),
         4'b0001, 8'd6);
    idle(6, 1'b1);

    // All requesters valid: one grant per cycle in rotation starting at ptr=1.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b1111, all_a, all_b, seq_all[i], 8'd10);
    idle(6, 1'b1);

    // Wraparound arithmetic from requester 1.
    step(1'b0, 1'b1, 4'b0010, pk(8'd0, 8'd3, 8'd0, 8'd0), pk(8'd0, 8'd9, 8'd0, 8'd0),
         4'b0010, 8'hFA);
    step(1'b0, 1'b1, 4'b0010, pk(8'd0, 8'd0, 8'd0, 8'd0), pk(8'd0, 8'd1, 8'd0, 8'd0),
         4'b0010, 8'hFF);
    idle(6, 1'b1);

    // Fairness with requesters 0 and 2 held valid; pointer sits at 2.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'b0101, pk(8'd20, 8'd0, 8'd7, 8'd0), pk(8'd5, 8'd0, 8'd8, 8'd0),
           (i % 2 == 0) ? 4'b0100 : 4'b0001, (i % 2 == 0) ? 8'hFF : 8'd15);
    end
    idle(6, 1'b1);

    // en low with two ops in flight: drain, then resume at saved pointer (3).
    step(1'b0, 1'b1, 4'b1111, all_a, all_b, 4'b0010, 8'd10);
    step(1'b0, 1'b1, 4'b1111, all_a, all_b, 4'b0100, 8'd10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111, all_a, all_b, 4'b0000, 8'h00);
    idle(4, 1'b0);
    step(1'b0, 1'b1, 4'b1111, all_a, all_b, 4'b1000, 8'd10);
    idle(6, 1'b1);

    // Reset with two ops in flight: they are dropped and the pointer returns to 0.
    step(1'b0, 1'b1, 4'b0110, all_a, all_b, 4'b0010, 8'd10);
    step(1'b0, 1'b1, 4'b0110, all_a, all_b, 4'b0100, 8'd10);
    step(1'b1, 1'b1, 4'b1111, all_a, all_b, 4'b0000, 8'h00);
    step(1'b1, 1'b1, 4'b1111, all_a, all_b, 4'b0000, 8'h00);
    step(1'b0, 1'b1, 4'b1111, all_a, all_b, 4'b0001, 8'd10);
    idle(8, 1'b1);

    for (int d = 0; d < 2; d++) chk("scoreboard_empty", d, 32'(q[d].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
